// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF measurement path.
package ro_puf_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 16;
    // Minimum synchroniser depth; also used by the RO mux and response shift logic
    localparam int MIN_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } ro_state_e;

endpackage

// File: rtl/ro_pair_counter_if.sv
// Request/result bundle between the PUF sequencer and the RO pair counter.
interface ro_pair_counter_if
    import ro_puf_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
);
    logic                   Start;
    logic                   Busy;
    logic                   Done;
    logic                   Response;
    logic                   Tie;
    logic                   Overflow;
    logic [COUNT_WIDTH-1:0] Count_a;
    logic [COUNT_WIDTH-1:0] Count_b;

    modport master (
        output Start,
        input  Busy, Done, Response, Tie, Overflow, Count_a, Count_b
    );

    modport slave (
        input  Start,
        output Busy, Done, Response, Tie, Overflow, Count_a, Count_b
    );
endinterface

// File: rtl/ro_edge_counter.sv
// Synchronises one RO output, detects rising edges and counts them with saturation.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ro_in,
    input  logic                   clear,
    input  logic                   count_en,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   saturated
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   sat_q, sat_d;
    logic                   rise;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], ro_in};
        prev_d  = sync_q[SYNC_STAGES-1];
        rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (count_en && rise) begin
            // An edge arriving at full scale is lost; remember that it happened
            if (count_q == '1) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count     = count_q;
    assign saturated = sat_q;

endmodule

// File: rtl/ro_pair_counter.sv
// Enables a pair of ring oscillators, counts their edges over a fixed window
// and turns the comparison into one PUF response bit.
module ro_pair_counter
    import ro_puf_pkg::*;
#(
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = MIN_SYNC_STAGES
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RO_a,
    input  logic              RO_b,
    output logic              RO_enable,
    ro_pair_counter_if.slave  bus
);

    localparam int TIMER_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW_CYCLES - 1);

    ro_state_e              state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   start_q, start_d;
    logic                   ro_enable_q, ro_enable_d;
    logic                   response_q, response_d;
    logic                   tie_q, tie_d;
    logic                   clear_counts;
    logic                   count_en;
    logic [COUNT_WIDTH-1:0] count_a, count_b;
    logic                   sat_a, sat_b;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        // Start only registers while idle, so requests made during a measurement are dropped
        start_d      = bus.Start && (state_q == ST_IDLE);
        response_d   = response_q;
        tie_d        = tie_q;
        clear_counts = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d      = ST_SETTLE;
                    timer_d      = '0;
                    clear_counts = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_MEASURE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (timer_q == WINDOW_LAST) begin
                    state_d = ST_COMPARE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_COMPARE: begin
                // Equal counts (including both saturated) give Tie=1 and Response=0
                response_d = (count_a > count_b);
                tie_d      = (count_a == count_b);
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ro_enable_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
    end

    assign count_en = (state_q == ST_MEASURE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            start_q     <= 1'b0;
            ro_enable_q <= 1'b0;
            response_q  <= 1'b0;
            tie_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            start_q     <= start_d;
            ro_enable_q <= ro_enable_d;
            response_q  <= response_d;
            tie_q       <= tie_d;
        end
    end

    ro_edge_counter #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_a (
        .clk       (Clk),
        .rst       (Reset),
        .ro_in     (RO_a),
        .clear     (clear_counts),
        .count_en  (count_en),
        .count     (count_a),
        .saturated (sat_a)
    );

    ro_edge_counter #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_b (
        .clk       (Clk),
        .rst       (Reset),
        .ro_in     (RO_b),
        .clear     (clear_counts),
        .count_en  (count_en),
        .count     (count_b),
        .saturated (sat_b)
    );

    assign RO_enable    = ro_enable_q;
    assign bus.Busy     = (state_q != ST_IDLE);
    assign bus.Done     = (state_q == ST_DONE);
    assign bus.Response = response_q;
    assign bus.Tie      = tie_q;
    assign bus.Overflow = sat_a | sat_b;
    assign bus.Count_a  = count_a;
    assign bus.Count_b  = count_b;

endmodule

// File: doc/ro_pair_counter.md
Name: ro_pair_counter

Overview:
- Measurement end of the ring-oscillator PUF.
- Drives the shared Enable of two ring oscillators.
- Counts rising edges of each RO_out over a fixed Clk-domain gate window.
- Compares the two counts and emits one PUF response bit, plus both raw counts for characterisation.
- Sits between the RO array (fed via an external challenge-selected mux pair) and the PUF response shift logic.

Parameters:
- COUNT_WIDTH, 16, width of each edge counter and count output.
- WINDOW_CYCLES, 1024, Clk cycles during which edges are counted; must be ≥1.
- SETTLE_CYCLES, 4, Clk cycles the rings run before counting starts; must be ≥1.
- SYNC_STAGES, 2, flip-flops in each RO_out synchroniser; must be ≥2.

Ports:
- Clk, input, 1, single clock; all state updates on its rising edge.
- Reset, input, 1, synchronous, active-high.
- Start, input, 1, request one measurement; sampled only in IDLE.
- RO_a, input, 1, RO_out of ring A; asynchronous to Clk.
- RO_b, input, 1, RO_out of ring B; asynchronous to Clk.
- RO_enable, output, 1, drives Enable of both rings.
- Busy, output, 1, high in every state except IDLE.
- Done, output, 1, one-cycle pulse when the result is valid.
- Response, output, 1, 1 when Count_a > Count_b, else 0.
- Tie, output, 1, 1 when Count_a == Count_b.
- Overflow, output, 1, 1 if either counter saturated this measurement.
- Count_a, output, COUNT_WIDTH, edges counted on RO_a.
- Count_b, output, COUNT_WIDTH, edges counted on RO_b.

Behaviour:
- Reset (synchronous, takes effect at next Clk edge, overrides everything, including mid-measurement):
  - State returns to IDLE.
  - RO_enable, Busy, Done, Response, Tie and Overflow go to 0.
  - Count_a, Count_b, all synchroniser flops and the window counter go to 0.
- FSM states: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE:
  - Start=1 → SETTLE; the edge counters and Overflow clear on this transition.
  - Start is ignored in every other state (no queuing).
- SETTLE:
  - RO_enable=1; lasts exactly SETTLE_CYCLES cycles, then → MEASURE.
  - Synchronisers run, but edges are not counted.
- MEASURE:
  - RO_enable=1; lasts exactly WINDOW_CYCLES cycles, then → COMPARE.
  - Edges are counted on every cycle of MEASURE and only then.
- COMPARE:
  - RO_enable=0; 1 cycle.
  - Registers Response and Tie from the final counts, then → DONE.
- DONE: Done=1 for exactly 1 cycle, then → IDLE.
- Latency: Start sampled at edge 0 → Done high in the cycle following edge SETTLE_CYCLES+WINDOW_CYCLES+2. Busy is high from edge 1 up to, but not including, the return to IDLE.
- Result hold: Response, Tie, Overflow, Count_a and Count_b hold their values from COMPARE until the next Start leaves IDLE, or until Reset.
- Edge detection:
  - RO_x passes through a SYNC_STAGES flop chain.
  - A rising edge is last-stage=1 while the previous sample was 0.
  - At most one edge per Clk cycle per ring; ring frequency must be < Clk/2 for exact counts (a system constraint, not checked).
- Counters saturate at 2^COUNT_WIDTH−1.
  - The first increment attempt at the maximum sets Overflow.
  - If both counters saturate: Tie=1, Response=0.
- Tie behaviour: a tie forces Response=0.
- RO_enable is a registered output, glitch-free, 0 in IDLE, COMPARE and DONE. This lets the rings stop between measurements to limit heating and cross-coupling.

Decomposition:
- Package ro_puf_pkg:
  - FSM state enum.
  - Default COUNT_WIDTH.
  - A minimum-SYNC_STAGES constant, shared with the RO mux and response shift logic.
- Sub-module ro_edge_counter, instanced twice:
  - Contents: synchroniser, rising-edge detect, saturating counter with clear and count-enable.
  - Outputs: count and saturated flag.

Test Plan (WINDOW_CYCLES=1000, SETTLE_CYCLES=4, Clk period 10 ns):
- Reset then idle 20 cycles → RO_enable=0, Busy=0, Done=0, all counts 0, no state change.
- RO_a period 80 ns, RO_b period 100 ns, pulse Start:
  - Done at exactly cycle 1006 after Start.
  - Count_a=125±1, Count_b=100±1, Response=1, Tie=0, Overflow=0.
- Same setup with rings swapped → Response=0, Tie=0, Count_a=100±1.
- Both rings driven by an identical 100 ns waveform → Count_a==Count_b=100±1, Tie=1, Response=0.
- COUNT_WIDTH=6 with RO_a period 40 ns → Count_a=63, Overflow=1, Response=1 unless RO_b also saturates.
- Reset asserted at MEASURE cycle 500, and Start pulsed during Busy in a separate run:
  - Reset run: next cycle IDLE, RO_enable=0, counts 0, no Done pulse.
  - Start-during-Busy run: Start ignored, exactly one Done pulse.
